// File: rtl/tcb_pkg.sv
// Shared TCB types: request/response field bundles and the per-port priority type.
package tcb_pkg;

    localparam int unsigned TCB_ADR = 32;
    localparam int unsigned TCB_DAT = 32;
    localparam int unsigned TCB_SLW = 8;
    localparam int unsigned TCB_BEN = TCB_DAT / TCB_SLW;

    // Priority value of one manager port; lower value wins.
    typedef int unsigned prio_t;

    typedef struct packed {
        logic               wen;
        logic [TCB_ADR-1:0] adr;
        logic [TCB_BEN-1:0] ben;
        logic [TCB_DAT-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DAT-1:0] rdt;
        logic               err;
    } tcb_rsp_t;

endpackage

// File: rtl/tcb_lib_prio_arbiter.sv
// Combinational fixed-priority arbiter: picks the valid port with the lowest
// priority value, lower index on ties, index 0 when nothing is valid.
module tcb_lib_prio_arbiter
    import tcb_pkg::*;
#(
    parameter int unsigned SPN = 3,
    parameter int unsigned SPL = $clog2(SPN),
    parameter prio_t       PRI [SPN-1:0] = '{2, 1, 0}
) (
    input  logic [SPN-1:0] vld_i,
    output logic [SPL-1:0] sel_o
);

    logic  found;
    prio_t best;

    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_o = '0;
        found = 1'b0;
        best  = '0;
        // Strict less-than keeps the earlier (lower) index on equal priority.
        for (int unsigned i = 0; i < SPN; i++) begin
            if (vld_i[i] && (!found || PRI[i] < best)) begin
                found = 1'b1;
                best  = PRI[i];
                sel_o = SPL'(i);
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbitrated_mux.sv
// Arbitrated TCB multiplexer: SPN managers share one subordinate; responses come
// back DLY cycles after each transfer and are steered to the issuing port.
module tcb_lib_arbitrated_mux
    import tcb_pkg::*;
#(
    parameter int unsigned ADR = TCB_ADR,
    parameter int unsigned DAT = TCB_DAT,
    parameter int unsigned SLW = TCB_SLW,
    parameter int unsigned BEN = DAT / SLW,
    parameter int unsigned DLY = 1,
    parameter int unsigned SPN = 3,
    parameter int unsigned SPL = $clog2(SPN),
    parameter prio_t       PRI [SPN-1:0] = '{2, 1, 0}
) (
    input  logic               clk,
    input  logic               rst,
    // manager-side ports
    input  logic [SPN-1:0]     sub_vld,
    input  logic [SPN-1:0]     sub_wen,
    input  logic [SPN*ADR-1:0] sub_adr,
    input  logic [SPN*BEN-1:0] sub_ben,
    input  logic [SPN*DAT-1:0] sub_wdt,
    output logic [SPN-1:0]     sub_rdy,
    output logic [SPN*DAT-1:0] sub_rdt,
    output logic [SPN-1:0]     sub_err,
    // subordinate-side port
    output logic               man_vld,
    output logic               man_wen,
    output logic [ADR-1:0]     man_adr,
    output logic [BEN-1:0]     man_ben,
    output logic [DAT-1:0]     man_wdt,
    input  logic               man_rdy,
    input  logic [DAT-1:0]     man_rdt,
    input  logic               man_err,
    // observation
    output logic [SPL-1:0]     sel
);

    tcb_req_t       req;
    tcb_rsp_t       rsp;
    logic           xfer;
    logic           rsp_vld;
    logic [SPL-1:0] rsp_sel;

    tcb_lib_prio_arbiter #(
        .SPN (SPN),
        .SPL (SPL),
        .PRI (PRI)
    ) u_arbiter (
        .vld_i (sub_vld),
        .sel_o (sel)
    );

    // Request multiplexer
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < SPN; i++) begin
            if (sel == SPL'(i)) begin
                req.wen = sub_wen[i];
                req.adr = sub_adr[i*ADR +: ADR];
                req.ben = sub_ben[i*BEN +: BEN];
                req.wdt = sub_wdt[i*DAT +: DAT];
            end
        end
    end

    assign man_vld = |sub_vld;
    assign man_wen = req.wen;
    assign man_adr = req.adr;
    assign man_ben = req.ben;
    assign man_wdt = req.wdt;

    // Only the granted, valid port sees ready; losers simply wait.
    always_comb begin
        sub_rdy = '0;
        for (int unsigned i = 0; i < SPN; i++) begin
            sub_rdy[i] = man_rdy & sub_vld[i] & (sel == SPL'(i));
        end
    end

    assign xfer = man_vld & man_rdy;

    if (DLY == 0) begin : g_comb
        assign rsp_vld = xfer;
        assign rsp_sel = sel;
    end else begin : g_pipe
        logic           rsp_vld_d;
        logic [SPL-1:0] rsp_sel_d;
        logic [DLY-1:0] rsp_vld_q;
        logic [SPL-1:0] rsp_sel_q [DLY];

        assign rsp_vld_d = xfer;
        assign rsp_sel_d = sel;

        // NOTE: state is updated with non-blocking assignments so every stage
        // samples the previous stage's old value, giving a true shift register.
        // NOTE: the index stages are reset along with the valids, keeping the
        // response steering X-free straight out of reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_vld_q <= '0;
                for (int unsigned s = 0; s < DLY; s++) begin
                    rsp_sel_q[s] <= '0;
                end
            end else begin
                rsp_vld_q[0] <= rsp_vld_d;
                rsp_sel_q[0] <= rsp_sel_d;
                for (int unsigned s = 1; s < DLY; s++) begin
                    rsp_vld_q[s] <= rsp_vld_q[s-1];
                    rsp_sel_q[s] <= rsp_sel_q[s-1];
                end
            end
        end

        assign rsp_vld = rsp_vld_q[DLY-1];
        assign rsp_sel = rsp_sel_q[DLY-1];
    end

    assign rsp = '{rdt: man_rdt, err: man_err};

    // Response demultiplexer: idle ports read zero.
    always_comb begin
        sub_rdt = '0;
        sub_err = '0;
        for (int unsigned i = 0; i < SPN; i++) begin
            if (rsp_vld && (rsp_sel == SPL'(i))) begin
                sub_rdt[i*DAT +: DAT] = rsp.rdt;
                sub_err[i]            = rsp.err;
            end
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbitrated_mux.sv
// Directed bench for tcb_lib_arbitrated_mux with default parameters (DLY=1, SPN=3).
module tb_tcb_lib_arbitrated_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sub_vld;
    logic [2:0]  sub_wen;
    logic [95:0] sub_adr;
    logic [11:0] sub_ben;
    logic [95:0] sub_wdt;
    logic [2:0]  sub_rdy;
    logic [95:0] sub_rdt;
    logic [2:0]  sub_err;
    logic        man_vld;
    logic        man_wen;
    logic [31:0] man_adr;
    logic [3:0]  man_ben;
    logic [31:0] man_wdt;
    logic        man_rdy;
    logic [31:0] man_rdt;
    logic        man_err;
    logic [1:0]  sel;

    int n_vec = 0;
    int n_err = 0;

    tcb_lib_arbitrated_mux dut (
        .clk     (clk),
        .rst     (rst),
        .sub_vld (sub_vld),
        .sub_wen (sub_wen),
        .sub_adr (sub_adr),
        .sub_ben (sub_ben),
        .sub_wdt (sub_wdt),
        .sub_rdy (sub_rdy),
        .sub_rdt (sub_rdt),
        .sub_err (sub_err),
        .man_vld (man_vld),
        .man_wen (man_wen),
        .man_adr (man_adr),
        .man_ben (man_ben),
        .man_wdt (man_wdt),
        .man_rdy (man_rdy),
        .man_rdt (man_rdt),
        .man_err (man_err),
        .sel     (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        sub_vld[p]          = v;
        sub_wen[p]          = w;
        sub_adr[p*32 +: 32] = a;
        sub_ben[p*4 +: 4]   = 4'hF;
        sub_wdt[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rdt_of(input int p);
        return sub_rdt[p*32 +: 32];
    endfunction

    initial begin
        rst     = 1'b1;
        sub_vld = '0;
        sub_wen = '0;
        sub_adr = '0;
        sub_ben = '0;
        sub_wdt = '0;
        man_rdy = 1'b0;
        man_rdt = '0;
        man_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        man_rdt = 32'hFFFF_FFFF;
        man_err = 1'b1;
        settle();

        // Reset state: no slot valid, so nothing leaks to any port.
        check("rst_rdt0", rdt_of(0), 32'h0);
        check("rst_rdt1", rdt_of(1), 32'h0);
        check("rst_rdt2", rdt_of(2), 32'h0);
        check("rst_err",  {29'h0, sub_err}, 32'h0);
        check("rst_sel",  {30'h0, sel}, 32'h0);
        check("rst_mvld", {31'h0, man_vld}, 32'h0);
        man_err = 1'b0;
        man_rdt = '0;

        // Simultaneous writes: granted 0, 1, 2 in consecutive cycles.
        tick();
        man_rdy = 1'b1;
        set_req(0, 1'b1, 1'b1, 32'h0000_0000, 32'h0302_0100);
        set_req(1, 1'b1, 1'b1, 32'h0000_0004, 32'h1312_1110);
        set_req(2, 1'b1, 1'b1, 32'h0000_000C, 32'h2322_2120);
        settle();
        check("wr0_sel", {30'h0, sel}, 32'd0);
        check("wr0_adr", man_adr, 32'h0000_0000);
        check("wr0_wdt", man_wdt, 32'h0302_0100);
        check("wr0_wen", {31'h0, man_wen}, 32'h1);
        check("wr0_ben", {28'h0, man_ben}, 32'hF);
        check("wr0_rdy", {29'h0, sub_rdy}, 32'b001);
        tick();
        sub_vld[0] = 1'b0;
        settle();
        check("wr1_sel", {30'h0, sel}, 32'd1);
        check("wr1_adr", man_adr, 32'h0000_0004);
        check("wr1_wdt", man_wdt, 32'h1312_1110);
        check("wr1_rdy", {29'h0, sub_rdy}, 32'b010);
        check("wr0_err", {29'h0, sub_err}, 32'h0);
        tick();
        sub_vld[1] = 1'b0;
        settle();
        check("wr2_sel", {30'h0, sel}, 32'd2);
        check("wr2_adr", man_adr, 32'h0000_000C);
        check("wr2_rdy", {29'h0, sub_rdy}, 32'b100);
        tick();
        sub_vld[2] = 1'b0;
        settle();
        check("wr_idle", {31'h0, man_vld}, 32'h0);

        // Simultaneous reads: each port gets its own data one cycle later.
        set_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h0000_000C, 32'h0);
        settle();
        check("rd0_wen", {31'h0, man_wen}, 32'h0);
        tick();
        sub_vld[0] = 1'b0;
        man_rdt = 32'h0302_0100;
        settle();
        check("rd0_p0", rdt_of(0), 32'h0302_0100);
        check("rd0_p1", rdt_of(1), 32'h0);
        check("rd0_p2", rdt_of(2), 32'h0);
        tick();
        sub_vld[1] = 1'b0;
        man_rdt = 32'h1312_1110;
        settle();
        check("rd1_p0", rdt_of(0), 32'h0);
        check("rd1_p1", rdt_of(1), 32'h1312_1110);
        check("rd1_p2", rdt_of(2), 32'h0);
        tick();
        sub_vld[2] = 1'b0;
        man_rdt = 32'h2322_2120;
        settle();
        check("rd2_p0", rdt_of(0), 32'h0);
        check("rd2_p1", rdt_of(1), 32'h0);
        check("rd2_p2", rdt_of(2), 32'h2322_2120);
        tick();
        man_rdt = 32'hDEAD_BEEF;
        settle();
        check("rd_idle", rdt_of(0) | rdt_of(1) | rdt_of(2), 32'h0);

        // Backpressure: port 2 alone, subordinate stalls for three cycles.
        man_rdy = 1'b0;
        set_req(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp_rdy", {29'h0, sub_rdy}, 32'b000);
            check("bp_sel", {30'h0, sel}, 32'd2);
            tick();
            check("bp_norsp", rdt_of(2), 32'h0);
        end
        man_rdy = 1'b1;
        settle();
        check("bp_go", {29'h0, sub_rdy}, 32'b100);
        tick();
        sub_vld[2] = 1'b0;
        man_rdt = 32'h0000_0055;
        settle();
        check("bp_rsp", rdt_of(2), 32'h0000_0055);

        // Preemption: port 0 arrives while port 2 is stalled and wins.
        tick();
        man_rdy = 1'b0;
        set_req(2, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        tick();
        settle();
        check("pre_sel2", {30'h0, sel}, 32'd2);
        set_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        settle();
        check("pre_sel0", {30'h0, sel}, 32'd0);
        check("pre_adr0", man_adr, 32'h0000_0040);
        man_rdy = 1'b1;
        settle();
        check("pre_rdy0", {29'h0, sub_rdy}, 32'b001);
        tick();
        sub_vld[0] = 1'b0;
        man_rdt = 32'h0000_0066;
        settle();
        check("pre_rsp0", rdt_of(0), 32'h0000_0066);
        check("pre_sel2b", {30'h0, sel}, 32'd2);
        check("pre_rdy2", {29'h0, sub_rdy}, 32'b100);
        tick();
        sub_vld[2] = 1'b0;
        man_rdt = 32'h0000_0077;
        settle();
        check("pre_rsp2", rdt_of(2), 32'h0000_0077);
        check("pre_rsp2_p0", rdt_of(0), 32'h0);

        // Error routing to port 1.
        tick();
        man_rdt = '0;
        set_req(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        sub_vld[1] = 1'b0;
        man_err = 1'b1;
        settle();
        check("err_route", {29'h0, sub_err}, 32'b010);
        tick();
        settle();
        check("err_gone", {29'h0, sub_err}, 32'b000);
        man_err = 1'b0;

        // Reset after a read transfer: nothing reaches any port afterwards.
        set_req(1, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
        tick();
        sub_vld[1] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        man_rdt = 32'hAAAA_5555;
        man_err = 1'b1;
        settle();
        check("rst1_rdt", rdt_of(0) | rdt_of(1) | rdt_of(2), 32'h0);
        check("rst1_err", {29'h0, sub_err}, 32'h0);

        // Transfer and reset on the same edge: the in-flight slot is dropped.
        man_err = 1'b0;
        man_rdt = '0;
        set_req(1, 1'b1, 1'b0, 32'h0000_0108, 32'h0);
        rst = 1'b1;
        tick();
        sub_vld[1] = 1'b0;
        rst = 1'b0;
        man_rdt = 32'hAAAA_5555;
        man_err = 1'b1;
        settle();
        check("rst2_rdt1", rdt_of(1), 32'h0);
        check("rst2_err", {29'h0, sub_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
